// File: rtl/flappy_pkg.sv
// Shared types for the pipe field: grid geometry, game state and pipe-mask helper.
// Columns are the outer packed dimension so green[c] is one 16-row column.
package flappy_pkg;

  localparam int GRID_N = 16;

  typedef logic [GRID_N-1:0][GRID_N-1:0] grid_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } game_state_t;

  // Column bitmap for a fresh pipe: solid except a gap_h-row opening starting at 1+sel.
  function automatic logic [GRID_N-1:0] pipe_mask(input logic [2:0] sel, input int gap_h);
    logic [GRID_N-1:0] m;
    int top;
    top = 1 + int'(sel);
    for (int r = 0; r < GRID_N; r++) begin
      m[r] = !((r >= top) && (r < top + gap_h));
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_field_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting toward bit 0.
// Loads SEED on reset; a nonzero seed keeps it out of the all-zero lock-up state.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= {fb, q[15:1]};
  end

endmodule

// File: rtl/pipe_field_gen.sv
// Pipe bitmap producer: spawns pipes at column 0 and scrolls them toward column 15.
// Optional PIPE_SPEEDUP_EN: scroll divisor halves every 8 spawned pipes (max 8x).
module pipe_field_gen
  import flappy_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned PIPE_SPACING = 4,
  parameter int unsigned GAP_H        = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       crash,
  output grid_t      green,
  output logic       step,
  output logic [7:0] pipe_count,
  output logic       running
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(PIPE_SPACING);
  localparam logic [SW-1:0] SP_LAST = SW'(PIPE_SPACING - 1);

  game_state_t   state, state_nxt;
  logic [TW-1:0] tick, tick_last;
  logic [SW-1:0] spacing;
  logic [15:0]   lfsr_q;
  logic [15:0]   new_col;
  logic          advance, wrap, clear;
  logic          unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:3];

`ifdef PIPE_SPEEDUP_EN
  logic [1:0] shamt;

  // The divisor follows pipe_count live; tick uses >= so a shrinking divisor wraps at once.
  always_comb begin
    shamt     = (pipe_count[7:3] > 5'd3) ? 2'd3 : pipe_count[4:3];
    tick_last = TW'((TICK_DIV >> shamt) - 1);
  end
`else
  assign tick_last = TW'(TICK_DIV - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (crash) state_nxt = ST_HALT;
      ST_HALT: if (start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The crash edge itself already counts as halted: no tick or scroll on it.
  assign advance = (state == ST_RUN) && !crash;
  assign wrap    = advance && (tick >= tick_last);
  assign clear   = (state == ST_HALT) && start;
  assign running = (state == ST_RUN);
  assign new_col = (spacing == '0) ? pipe_mask(lfsr_q[2:0], int'(GAP_H)) : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      green      <= '0;
      step       <= 1'b0;
      pipe_count <= 8'd0;
      tick       <= '0;
      spacing    <= '0;
    end else begin
      step <= wrap;
      if (clear) begin
        green      <= '0;
        pipe_count <= 8'd0;
        tick       <= '0;
        spacing    <= '0;
      end else if (advance) begin
        if (wrap) begin
          tick    <= '0;
          green   <= {green[GRID_N-2:0], new_col};
          spacing <= (spacing == SP_LAST) ? '0 : spacing + SW'(1);
          if ((spacing == '0) && (pipe_count != 8'hFF)) pipe_count <= pipe_count + 8'd1;
        end else begin
          tick <= tick + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_field_gen.sv
// Bench for pipe_field_gen: directed scenarios plus random start/crash/rst traffic,
// checked each cycle against a step-history model of the pipe field.
module tb_pipe_field_gen;
  import flappy_pkg::*;

  localparam int TD = 8;
  localparam int SP = 4;
  localparam int GH = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       crash = 1'b0;
  grid_t      green;
  logic       step;
  logic [7:0] pipe_count;
  logic       running;

  pipe_field_gen #(
    .TICK_DIV(TD), .PIPE_SPACING(SP), .GAP_H(GH), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .crash(crash),
    .green(green), .step(step), .pipe_count(pipe_count), .running(running)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 run, 2 halt; field kept as a history of spawned columns.
  int          m_mode, m_cyc, m_steps, m_count;
  bit          m_step;
  bit          m_valid = 0;
  logic [15:0] m_lfsr;
  logic [15:0] m_cols[$];

  function automatic int period(input int cnt);
    int k;
    k = cnt / 8;
    if (k > 3) k = 3;
`ifndef PIPE_SPEEDUP_EN
    k = 0;
`endif
    return TD >> k;
  endfunction

  function automatic logic [15:0] model_mask(input logic [15:0] lf);
    logic [15:0] m;
    int g;
    g = 1 + int'(lf[2:0]);
    for (int r = 0; r < 16; r++) m[r] = (r < g) || (r >= g + GH);
    return m;
  endfunction

  function automatic grid_t model_green();
    grid_t g;
    g = '0;
    for (int c = 0; c < 16; c++) if (c < m_cols.size()) g[c] = m_cols[c];
    return g;
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] cur;
    cur    = m_lfsr;
    m_step = 0;
    if (rst) begin
      m_mode = 0; m_cyc = 0; m_steps = 0; m_count = 0;
      m_cols.delete();
      m_lfsr  = SEED;
      m_valid = 1;
    end else begin
      m_lfsr = {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
      if (m_mode == 0) begin
        if (start) m_mode = 1;
      end else if (m_mode == 1) begin
        if (crash) m_mode = 2;
        else begin
          m_cyc++;
          if (m_cyc >= period(m_count)) begin
            m_cyc  = 0;
            m_step = 1;
            if (m_steps % SP == 0) begin
              m_cols.push_front(model_mask(cur));
              if (m_count < 255) m_count++;
            end else begin
              m_cols.push_front(16'h0000);
            end
            if (m_cols.size() > 16) void'(m_cols.pop_back());
            m_steps++;
          end
        end
      end else if (start) begin
        m_mode = 0; m_cyc = 0; m_steps = 0; m_count = 0;
        m_cols.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_step", {255'd0, step}, {255'd0, m_step});
      check("m_running", {255'd0, running}, {255'd0, (m_mode == 1)});
      check("m_count", {248'd0, pipe_count}, 256'(m_count));
      check("m_green", green, model_green());
    end
  end

  // Cycles (negedges) until the next step pulse; a timeout counts as a failure.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 200);
    if (!step) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_step: no step within %0d cycles", n);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    int n, s, g, lim, expp;
    logic [15:0] col, z;

    repeat (3) @(negedge clk);
    check("rst_green", green, 256'd0);
    check("rst_step", {255'd0, step}, 256'd0);
    check("rst_count", {248'd0, pipe_count}, 256'd0);
    check("rst_running", {255'd0, running}, 256'd0);
    rst = 1'b0;

    pulse_start();
    wait_step(n);
    check("first_step_cycle", n, 8);
    check("step1_count", {248'd0, pipe_count}, 1);
    col = green[0];
    check("col0_frame", {251'd0, col[0], col[15:12]}, 5'b11111);
    z = ~col;
    g = 0;
    while (g < 16 && !z[g]) g++;
    check("col0_gap", {255'd0, (z == (16'h000F << g)) && g >= 1 && g <= 8}, 1);

    for (int k = 2; k <= 4; k++) begin
      wait_step(n);
      check("period8", n, 8);
    end
    check("cols0to2_empty", {208'd0, green[2], green[1], green[0]}, 256'd0);
    check("col3_pipe", {240'd0, green[3]}, {240'd0, col});
    wait_step(n);
    check("step5_count", {248'd0, pipe_count}, 2);
    for (int k = 6; k <= 16; k++) wait_step(n);
    check("col15_row14", {255'd0, green[15][14]}, 1);
    wait_step(n);
    check("col15_gone", {240'd0, green[15]}, 256'd0);

    @(negedge clk); crash = 1'b1;
    @(negedge clk); crash = 1'b0;
    s = 0;
    repeat (100) begin
      @(negedge clk);
      s += int'(step);
    end
    check("halt_no_step", s, 0);
    check("halt_count", {248'd0, pipe_count}, 5);
    pulse_start();
    check("idle_green", green, 256'd0);
    check("idle_count", {248'd0, pipe_count}, 0);
    check("idle_running", {255'd0, running}, 0);
    pulse_start();
    check("rerun_running", {255'd0, running}, 1);

    wait_step(n);
    check("rerun_first_step", n, 8);
    @(negedge clk); start = 1'b1; crash = 1'b1;
    @(negedge clk); start = 1'b0; crash = 1'b0;
    check("both_halt_running", {255'd0, running}, 0);
    check("both_halt_count", {248'd0, pipe_count}, 1);
    pulse_start();
    pulse_start();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_green", green, 256'd0);
    check("midrst_running", {255'd0, running}, 0);
    check("midrst_count", {248'd0, pipe_count}, 0);

    pulse_start();
    for (int t = 8; t <= 24; t += 8) begin
      lim = 0;
      while (!(step && pipe_count == 8'(t)) && lim < 5000) begin
        @(negedge clk);
        lim++;
      end
      wait_step(n);
`ifdef PIPE_SPEEDUP_EN
      expp = TD >> (t / 8);
`else
      expp = TD;
`endif
      check("speed_period", n, expp);
    end

    repeat (8500) @(negedge clk);
    check("count_saturated", {248'd0, pipe_count}, 255);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 39) == 0);
      crash = ($urandom_range(0, 149) == 0);
      rst   = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    start = 1'b0; crash = 1'b0; rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
